// File: rtl/seq_booth_r4_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, WIDTH/2+1 cycles per product.
// Handles signed and unsigned operands via extension of both operands before recoding.
module seq_booth_r4_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int P  = 2 * WIDTH + 4;
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("seq_booth_r4_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [P-1:0]   mc_sh;
    logic [P-1:0]   acc;
    logic [P-1:0]   sel;
    logic [P-1:0]   pp;
    logic [P-1:0]   next_acc;
    logic [WIDTH+2:0] mq;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           a_sx;
    logic           b_sx;

    // Multiplicand is pre-shifted by 2 each cycle instead of shifting the accumulator.
    always_comb begin
        a_sx = signed_mode & a[WIDTH-1];
        b_sx = signed_mode & b[WIDTH-1];
        sel  = '0;
        neg  = 1'b0;
        case (mq[2:0])
            3'b001, 3'b010: sel = mc_sh;
            3'b011:         sel = mc_sh << 1;
            3'b100: begin
                sel = mc_sh << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = mc_sh;
                neg = 1'b1;
            end
            default:        sel = '0;
        endcase
        pp       = neg ? ('0 - sel) : sel;
        next_acc = acc + pp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mc_sh   <= '0;
            mq      <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mc_sh <= {{(P-WIDTH){a_sx}}, a};
                        mq    <= {{2{b_sx}}, b, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= next_acc;
                    mc_sh <= mc_sh << 2;
                    mq    <= mq >> 2;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        product <= next_acc[2*WIDTH-1:0];
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_r4_mult.sv
// Scoreboard bench for seq_booth_r4_mult (WIDTH=32): directed corner cases plus random operands,
// expected products from plain 64-bit arithmetic, latency checked against accept time.
module tb_seq_booth_r4_mult;

    localparam int  W      = 32;
    localparam time PERIOD = 10;
    localparam time LAT    = (W / 2 + 1) * PERIOD + PERIOD / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W-1:0] p;
        time            due;
    } exp_t;

    exp_t           sbq[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [2*W-1:0] last_prod = '0;
    logic           prev_done = 1'b0;

    seq_booth_r4_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #(PERIOD / 2) clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] xe;
        logic signed [2*W-1:0] ye;
        xe = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge while the DUT is idle or in its done cycle.
    task automatic issue(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        start = 1'b1;
        signed_mode = sm;
        a = x;
        b = y;
        @(posedge clk);
        e.p   = ref_mul(sm, x, y);
        e.due = $time + LAT;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        signed_mode = 1'($urandom);
        chk("busy_in_run", 64'(busy), 64'd1);
        chk("product_hold", product, last_prod);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic run_op(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(sm, x, y);
        wait_done();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: product %h with empty scoreboard at %0t", product, $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("product", product, e.p);
                    chk("latency", 64'($time), 64'(e.due));
                    last_prod = e.p;
                end
                chk("done_single_cycle", 64'(prev_done), 64'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(1'b1, -32'sd51, -32'sd4);
        run_op(1'b1, 32'd12, -32'sd32);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
        run_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op(1'b0, 32'd0, 32'd0);

        // start while busy must be ignored
        issue(1'b1, 32'd5, 32'd15);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a = 32'd1;
        b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // asynchronous abort mid-run, then rerun
        issue(1'b0, 32'd13, 32'd20);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        sbq.delete();
        last_prod = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        run_op(1'b0, 32'd13, 32'd20);

        // back-to-back accept from the done cycle
        issue(1'b1, 32'd3, -32'sd7);
        wait_done();
        issue(1'b1, 32'd72, -32'sd12);
        wait_done();
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom), pick(), pick());
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
